// File: rtl/rs422_pkg.sv
// Shared types and constants for the RS-422 command-frame parser.
// Optional feature macro: RS422_PARSER_TIMEOUT_EN (inter-byte timeout).
package rs422_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_CMD  = 3'd1,
    S_LEN  = 3'd2,
    S_DATA = 3'd3,
    S_CSUM = 3'd4
  } state_t;

  localparam logic [7:0] FRAME_HEADER = 8'hA5;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_CSUM    = 2'b01;
  localparam logic [1:0] ERR_LEN     = 2'b10;
  localparam logic [1:0] ERR_TIMEOUT = 2'b11;

endpackage

// File: rtl/rs422_byte_timer.sv
// Inter-byte watchdog: counts cycles while running, clears on request,
// and flags expiry on the cycle the count reaches LIMIT-1 without a clear.
// Only instantiated when RS422_PARSER_TIMEOUT_EN is defined.
module rs422_byte_timer #(
  parameter int LIMIT = 500000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic run,
  output logic expired
);

  localparam int CW = $clog2(LIMIT + 1);
  localparam logic [CW-1:0] LAST = CW'(LIMIT - 1);

  logic [CW-1:0] count;

  // Count while running; any clear (accepted byte or idle) restarts from zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear || !run) begin
      count <= '0;
    end else if (count != LAST) begin
      count <= count + 1'b1;
    end
  end

  // A byte arriving on the final cycle wins over expiry.
  assign expired = run && !clear && (count == LAST);

endmodule

// File: rtl/rs422_frame_parser.sv
// RS-422 command-frame parser: A5 | CMD | LEN | payload[LEN] | CSUM.
// CSUM is the 8-bit wrap-around sum of CMD, LEN and payload.
// Optional feature macro: RS422_PARSER_TIMEOUT_EN (inter-byte timeout, err 11).
//
// Handshake: rx_valid is a one-cycle strobe qualifying rx_data; there is no
// ready, every strobe is consumed in the cycle it appears, back-to-back allowed.
module rs422_frame_parser
  import rs422_pkg::*;
#(
  parameter int MAX_LEN        = 8,
  parameter int TIMEOUT_CYCLES = 500000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [7:0]           rx_data,
  input  logic                 rx_valid,
  output logic                 frame_valid,
  output logic [7:0]           cmd,
  output logic [3:0]           payload_len,
  output logic [MAX_LEN*8-1:0] payload,
  output logic                 frame_err,
  output logic [1:0]           err_code,
  output logic                 busy,
  output logic [2:0]           state_dbg
);

  localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

  state_t               state;
  logic [7:0]           sum;
  logic [7:0]           cmd_stage;
  logic [3:0]           len_stage;
  logic [3:0]           idx;
  logic [MAX_LEN*8-1:0] stage;
  logic                 tmo_expired;

`ifdef RS422_PARSER_TIMEOUT_EN
  rs422_byte_timer #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (rx_valid || (state == S_IDLE)),
    .run     (state != S_IDLE),
    .expired (tmo_expired)
  );
`else
  // Without the watchdog the parser waits indefinitely in any state.
  assign tmo_expired = 1'b0;
`endif

  assign busy      = (state != S_IDLE);
  assign state_dbg = state;

  // Frame FSM: staging is private; outputs update only on a good checksum.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      sum         <= '0;
      cmd_stage   <= '0;
      len_stage   <= '0;
      idx         <= '0;
      stage       <= '0;
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
      err_code    <= ERR_NONE;
      cmd         <= '0;
      payload_len <= '0;
      payload     <= '0;
    end else begin
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
      if (rx_valid) begin
        case (state)
          S_IDLE: begin
            if (rx_data == FRAME_HEADER) state <= S_CMD;
          end
          S_CMD: begin
            cmd_stage <= rx_data;
            sum       <= rx_data;
            stage     <= '0;
            state     <= S_LEN;
          end
          S_LEN: begin
            sum       <= sum + rx_data;
            len_stage <= rx_data[3:0];
            idx       <= '0;
            if (rx_data > MAX_LEN_B) begin
              frame_err <= 1'b1;
              err_code  <= ERR_LEN;
              state     <= S_IDLE;
            end else if (rx_data == 8'd0) begin
              state <= S_CSUM;
            end else begin
              state <= S_DATA;
            end
          end
          S_DATA: begin
            for (int i = 0; i < MAX_LEN; i++) begin
              if (idx == 4'(i)) stage[i*8 +: 8] <= rx_data;
            end
            sum <= sum + rx_data;
            idx <= idx + 4'd1;
            if (idx + 4'd1 == len_stage) state <= S_CSUM;
          end
          S_CSUM: begin
            if (rx_data == sum) begin
              frame_valid <= 1'b1;
              cmd         <= cmd_stage;
              payload_len <= len_stage;
              payload     <= stage;
            end else begin
              frame_err <= 1'b1;
              err_code  <= ERR_CSUM;
            end
            state <= S_IDLE;
          end
          default: state <= S_IDLE;
        endcase
      end else if (tmo_expired) begin
        frame_err <= 1'b1;
        err_code  <= ERR_TIMEOUT;
        state     <= S_IDLE;
      end
    end
  end

endmodule
